// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: drives a universal shift register through load + counted shifts and streams exiting bits; USR_SEQ_ROTATE_EN enables rotate fill
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_fill,
  input  logic             in_rot,
  input  logic [WIDTH-1:0] a_in,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] I,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q, rem;
  logic dir_q, fill_q, rot_q, shifting, out_bit, fill_bit;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state  <= IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      rem    <= '0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        data_q <= in_data;
        dir_q  <= in_dir;
        fill_q <= in_fill;
        cnt_q  <= in_count > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : in_count;
      end
      if (state == LOAD) rem <= cnt_q;
      else if (state == SHIFT) rem <= rem - CNT_W'(1);
    end
  end
`ifdef USR_SEQ_ROTATE_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) rot_q <= 1'b0;
    else if (state == IDLE && in_valid) rot_q <= in_rot;
  end
`else
  logic unused_rot;
  assign unused_rot = in_rot;
  assign rot_q = 1'b0;
`endif
  always_comb begin
    state_n   = state == IDLE  ? (in_valid ? LOAD : IDLE) :
                state == LOAD  ? (cnt_q == '0 ? DONE : SHIFT) :
                state == SHIFT ? (rem == CNT_W'(1) ? DONE : SHIFT) : IDLE;
    shifting  = state == SHIFT;
    out_bit   = dir_q ? a_in[WIDTH-1] : a_in[0];
    fill_bit  = rot_q ? out_bit : fill_q;
    in_ready  = state == IDLE;
    S         = state == LOAD ? 2'b11 : shifting ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
    I         = state == LOAD ? data_q : '0;
    MSB_in    = shifting && !dir_q && fill_bit;
    LSB_in    = shifting && dir_q && fill_bit;
    ser_out   = shifting && out_bit;
    ser_valid = shifting;
    done      = state == DONE;
  end
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb_usr_shift_sequencer: scoreboard bench closing the loop through a behavioural USR
module tb_usr_shift_sequencer;
  logic clk = 1'b0, clear = 1'b0, in_valid = 1'b0, in_dir = 1'b0, in_fill = 1'b0, in_rot = 1'b0;
  logic [3:0] in_data = '0, a, I;
  logic [2:0] in_count = '0;
  logic [1:0] S;
  logic in_ready, MSB_in, LSB_in, ser_out, ser_valid, done;
  int nchk = 0, nfail = 0, cyc = 0;
  typedef struct {int kind; logic [3:0] val; logic [1:0] s; int cyc;} exp_t;
  exp_t sb[$];
`ifdef USR_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif
  usr_shift_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .in_count(in_count), .in_fill(in_fill), .in_rot(in_rot), .a_in(a),
    .S(S), .I(I), .MSB_in(MSB_in), .LSB_in(LSB_in), .ser_out(ser_out),
    .ser_valid(ser_valid), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk or negedge clear) begin
    if (!clear) a <= '0;
    else case (S)
      2'b01: a <= {MSB_in, a[3:1]};
      2'b10: a <= {a[2:0], LSB_in};
      2'b11: a <= I;
      default: a <= a;
    endcase
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (clear && (S == 2'b11 || ser_valid || done)) begin
      if (sb.size() == 0) chk("unexpected_output", {S, ser_valid, done}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("kind", done ? 2 : ser_valid ? 1 : 0, e.kind);
        chk("cycle", cyc, e.cyc);
        if (e.kind == 0) chk("load_I", I, e.val);
        if (e.kind == 1) begin
          chk("ser_out", ser_out, e.val[0]);
          chk("shift_S", S, e.s);
        end
        if (e.kind == 2) begin
          chk("final_A", a, e.val);
          chk("ready_in_done", in_ready, 0);
        end
      end
    end
  end
  task automatic issue(input logic [3:0] d, input bit dir, input int n, input bit f, input bit r,
                       input bit wait_end);
    int nc, w, fm, acc;
    logic [3:0] ae;
    in_valid = 1'b1; in_data = d; in_dir = dir; in_count = 3'(n); in_fill = f; in_rot = r;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    in_data = 4'($urandom); in_dir = 1'($urandom); in_count = 3'($urandom);
    in_fill = 1'($urandom); in_rot = 1'($urandom);
    nc = n > 4 ? 4 : n;
    w = int'(d);
    fm = (1 << nc) - 1;
    if (ROT_EN && r) ae = dir ? 4'((w << nc) | (w >> (4 - nc))) : 4'((w >> nc) | (w << (4 - nc)));
    else ae = dir ? 4'((w << nc) | (f ? fm : 0)) : 4'((w >> nc) | (f ? fm << (4 - nc) : 0));
    sb.push_back('{0, d, 2'b11, acc});
    for (int k = 0; k < nc; k++)
      sb.push_back('{1, {3'b0, dir ? d[3 - k] : d[k]}, dir ? 2'b10 : 2'b01, acc + 1 + k});
    sb.push_back('{2, ae, 2'b00, acc + 1 + nc});
    if (wait_end) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (in_ready) break;
      end
      chk("ready_return", cyc, acc + nc + 2);
    end
  endtask
  initial begin
    in_valid = 1'b1; in_data = 4'b1011; in_count = 3'd4;
    repeat (3) @(negedge clk);
    chk("rst_S", S, 0);
    chk("rst_I", I, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_serial_fill", {MSB_in, LSB_in, ser_out}, 0);
    clear = 1'b1;
    issue(4'b1011, 0, 4, 0, 0, 1);
    issue(4'b1011, 1, 2, 1, 0, 1);
    issue(4'b0110, 0, 0, 1, 1, 1);
    issue(4'b1101, 1, 7, 0, 0, 1);
    issue(4'b1001, 0, 4, 0, 1, 1);
    issue(4'b1001, 1, 3, 1, 1, 1);
    issue(4'b1101, 0, 4, 1, 0, 0);
    repeat (3) @(negedge clk);
    #2 clear = 1'b0;
    #1;
    chk("abort_S", S, 0);
    chk("abort_I", I, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_ser_valid", ser_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_A", a, 0);
    #1 clear = 1'b1;
    sb.delete();
    repeat (8) @(negedge clk);
    issue(4'b0111, 0, 2, 1, 0, 1);
    for (int j = 0; j < 40; j++)
      issue(4'($urandom), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/usr_shift_sequencer.md
# usr_shift_sequencer

Control stage directly upstream of the 4-bit universal shift register (USR). Accepts a word plus a shift job over a valid/ready handshake, then drives the USR's mode select, parallel input and serial fill inputs. It parallel-loads the word and issues a counted run of right or left shifts. It watches the USR's parallel output and presents each bit leaving the register as a serial stream with a valid strobe.

## Interface
- WIDTH, default 4: USR width; must equal the attached USR.
- Local CNT_W = $clog2(WIDTH+1): width of the shift-count field.
- clk  in  1  clock, rising edge; shared with the USR.
- clear  in  1  asynchronous active-low reset; shared with the USR's clear.
- in_valid  in  1  job offered.
- in_ready  out  1  sequencer idle and able to accept.
- in_data  in  WIDTH  word to parallel-load.
- in_dir  in  1  0 = shift right (toward bit 0), 1 = shift left.
- in_count  in  CNT_W  number of shifts; values above WIDTH clamp to WIDTH.
- in_fill  in  1  bit shifted into the vacated end.
- in_rot  in  1  rotate request; used only under USR_SEQ_ROTATE_EN.
- a_in  in  WIDTH  USR parallel output A, fed back.
- S  out  2  USR mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- I  out  WIDTH  USR parallel input.
- MSB_in  out  1  USR serial input for right shifts.
- LSB_in  out  1  USR serial input for left shifts.
- ser_out  out  1  bit leaving the USR this cycle.
- ser_valid  out  1  ser_out is meaningful.
- done  out  1  one-cycle job-complete pulse.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- All outputs are Moore-decoded from the state and latched job registers. The exception is ser_out and the rotate fill, which are combinational from a_in in SHIFT.
- IDLE:
  - in_ready=1; S=00; I, MSB_in, LSB_in, ser_out, ser_valid and done are all 0.
  - When in_valid&&in_ready at a clock edge, latch data, dir, clamped count, fill and rot, then go to LOAD.
- LOAD, one cycle:
  - S=11; I=latched data. The USR loads at the closing edge.
  - Next state is SHIFT with remaining=count, or DONE if count==0.
- SHIFT:
  - Right shift: S=01; ser_out=a_in[0]; MSB_in=fill; LSB_in=0.
  - Left shift: S=10; ser_out=a_in[WIDTH-1]; LSB_in=fill; MSB_in=0.
  - ser_valid=1.
  - remaining decrements at each edge; the edge with remaining==1 goes to DONE.
- DONE, one cycle: S=00; done=1; in_ready=0; then return to IDLE.
- I holds 0 outside LOAD.
- Inputs other than a_in are ignored outside the IDLE accept edge. Changing in_* mid-job has no effect.

## Timing
- Reset:
  - clear low forces IDLE immediately, independent of clk.
  - S=00, I=0, MSB_in=0, LSB_in=0, ser_out=0, ser_valid=0, done=0, in_ready=1. Remaining count and latched job are cleared.
  - No job is accepted while clear is low.
- Latency, with acceptance at edge 0:
  - LOAD occupies cycle 1.
  - Shifts occupy cycles 2..N+1.
  - done is high in cycle N+2.
  - in_ready returns in cycle N+3. Back-to-back jobs therefore have a gap of N+3 cycles.
- Serial bit k (k=0..N-1) is valid in cycle k+2 and equals the USR bit at the exit end before that cycle's shift edge.
- Clear asserted mid-job aborts it: no done pulse, and the USR is cleared by the same signal.
- Count clamping is applied at latch time, e.g. WIDTH=4 with in_count=7 performs 4 shifts.

## Configuration
- USR_SEQ_ROTATE_EN defined: when the latched rot=1, the fill bit in SHIFT is the outgoing bit (MSB_in=a_in[0] for right, LSB_in=a_in[WIDTH-1] for left). After WIDTH shifts the USR holds the original word. With rot=0, fill is in_fill.
- USR_SEQ_ROTATE_EN undefined: in_rot is ignored and not latched; fill is always in_fill.

## Test plan
- Reset: hold clear low with in_valid=1 -> S=00, in_ready=1, ser_valid=0, done=0, no job accepted. Release clear -> job accepted on the next edge.
- Right shift: data=1011, dir=0, count=4, fill=0 -> LOAD cycle shows S=11, I=1011; then 4 cycles of S=01 with ser_out=1,1,0,1; done in cycle 6; USR A=0000.
- Left shift: data=1011, dir=1, count=2, fill=1 -> ser_out=1,0 with S=10; USR A=1111; done in cycle 4.
- Count boundaries:
  - count=0 with data=0110 -> LOAD then DONE, ser_valid never high, A=0110.
  - count=7 -> exactly 4 shift cycles.
- Rotate: data=1001, dir=0, count=4, rot=1, fill=0.
  - With USR_SEQ_ROTATE_EN: ser_out=1,0,0,1 and A=1001.
  - Without USR_SEQ_ROTATE_EN: A=0000.
- Mid-job reset: pulse clear low during the 2nd SHIFT cycle -> outputs return to reset values asynchronously, no done pulse, A=0000; a new job is accepted normally afterwards.
